// File: rtl/bin2bcd_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module   : bin2bcd_seq_pkg
// Brief    : Shared BCD constants, FSM state encoding and digit-adjust helper.
// Revision : 1.0 - initial release
// ============================================================================
package bin2bcd_seq_pkg;

    localparam int c_BCD_DIGIT_W    = 4;
    localparam int c_BCD_ADJ_THRESH = 5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CONV = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    function automatic logic [c_BCD_DIGIT_W-1:0] bcd_adjust(input logic [c_BCD_DIGIT_W-1:0] d);
        return (d >= c_BCD_DIGIT_W'(c_BCD_ADJ_THRESH)) ? d + c_BCD_DIGIT_W'(3) : d;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bin2bcd_seq_add3.sv
`default_nettype none
// ============================================================================
// Module   : add3_digit
// Brief    : Combinational double-dabble digit correction (+3 when >= 5).
// Revision : 1.0 - initial release
// ============================================================================
module add3_digit (
    input  logic [3:0] i_digit,
    output logic [3:0] o_digit
);
    import bin2bcd_seq_pkg::*;

    assign o_digit = bcd_adjust(i_digit);

endmodule
`default_nettype wire

// File: rtl/bin2bcd_seq.sv
`default_nettype none
// ============================================================================
// Module   : bin2bcd_seq
// Brief    : Sequential shift-and-add-3 binary-to-BCD converter, one bit/clock,
//            start/busy/done handshake. Define BIN2BCD_SAT_EN to saturate
//            out-of-range inputs to all-nines and flag ovf.
// Revision : 1.0 - initial release
// ============================================================================
module bin2bcd_seq #(
    parameter int W    = 14,
    parameter int NDIG = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [W-1:0]      bin,
    output logic              busy,
    output logic              done,
    output logic [4*NDIG-1:0] bcd,
    output logic              ovf
);
    import bin2bcd_seq_pkg::*;

    localparam int c_BW    = c_BCD_DIGIT_W * NDIG;
    localparam int c_CNT_W = (W > 1) ? $clog2(W) : 1;

    state_t             r_state;
    logic [c_CNT_W-1:0] r_cnt;
    logic [c_BW-1:0]    r_bcd_work;
    logic [W-1:0]       r_bin_work;
    logic [c_BW-1:0]    w_adj;
    logic [c_BW-1:0]    w_bcd_result;

    generate
        for (genvar g = 0; g < NDIG; g++) begin : g_add3
            add3_digit u_add3 (
                .i_digit (r_bcd_work[g*c_BCD_DIGIT_W +: c_BCD_DIGIT_W]),
                .o_digit (w_adj[g*c_BCD_DIGIT_W +: c_BCD_DIGIT_W])
            );
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_bcd_work <= '0;
            r_bin_work <= '0;
            bcd        <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_bcd_work <= '0;
                        r_bin_work <= bin;
                        r_cnt      <= c_CNT_W'(W - 1);
                        busy       <= 1'b1;
                        r_state    <= ST_CONV;
                    end
                end
                ST_CONV: begin
                    // Adjusted digits shift up; the top digit's MSB falls off.
                    r_bcd_work <= {w_adj[c_BW-2:0], r_bin_work[W-1]};
                    r_bin_work <= {r_bin_work[W-2:0], 1'b0};
                    r_cnt      <= r_cnt - c_CNT_W'(1);
                    if (r_cnt == '0) begin
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    done    <= 1'b1;
                    bcd     <= w_bcd_result;
                    busy    <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    busy    <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef BIN2BCD_SAT_EN
    // Any 1 leaving the top digit means the value needs a fifth digit.
    logic r_carry;
    logic r_ovf;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_carry <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            if (r_state == ST_IDLE && start) begin
                r_carry <= 1'b0;
            end else if (r_state == ST_CONV) begin
                r_carry <= r_carry | w_adj[c_BW-1];
            end
            if (r_state == ST_DONE) begin
                r_ovf <= r_carry;
            end
        end
    end

    assign w_bcd_result = r_carry ? {NDIG{4'h9}} : r_bcd_work;
    assign ovf          = r_ovf;
`else
    logic w_unused_carry;

    assign w_unused_carry = w_adj[c_BW-1];
    assign w_bcd_result   = r_bcd_work;
    assign ovf            = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_bin2bcd_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_bin2bcd_seq
// Brief    : Self-checking bench for bin2bcd_seq with a decimal-arithmetic model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bin2bcd_seq;

    localparam int W    = 14;
    localparam int NDIG = 4;
    localparam int LAT  = W + 1;

    logic              clk   = 1'b0;
    logic              rst   = 1'b1;
    logic              start = 1'b0;
    logic [W-1:0]      bin   = '0;
    logic              busy;
    logic              done;
    logic [4*NDIG-1:0] bcd;
    logic              ovf;

    int total = 0;
    int bad   = 0;
    int n_done = 0;

    bin2bcd_seq #(.W(W), .NDIG(NDIG)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .bin   (bin),
        .busy  (busy),
        .done  (done),
        .bcd   (bcd),
        .ovf   (ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] exp_bcd(input int v);
        int r;
`ifdef BIN2BCD_SAT_EN
        if (v > 9999) return 16'h9999;
`endif
        r = v % 10000;
        return {4'(r / 1000), 4'((r / 100) % 10), 4'((r / 10) % 10), 4'(r % 10)};
    endfunction

    function automatic logic exp_ovf(input int v);
`ifdef BIN2BCD_SAT_EN
        return v > 9999;
`else
        return (v < 0);
`endif
    endfunction

    // Model: a request is accepted when idle; result appears LAT edges later.
    int          m_left = 0;
    int          m_pend = 0;
    logic        m_busy = 1'b0;
    logic        m_done = 1'b0;
    logic        m_ovf  = 1'b0;
    logic [15:0] m_bcd  = '0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_left = 0;
            m_busy = 1'b0;
            m_done = 1'b0;
            m_ovf  = 1'b0;
            m_bcd  = '0;
        end else begin
            m_done = 1'b0;
            if (m_left > 0) begin
                m_left--;
                if (m_left == 0) begin
                    m_done = 1'b1;
                    m_bcd  = exp_bcd(m_pend);
                    m_ovf  = exp_ovf(m_pend);
                end
            end else if (start) begin
                m_left = LAT;
                m_pend = int'(bin);
            end
            m_busy = (m_left > 0);
        end
    end

    always @(negedge clk) begin
        chk("cyc_busy", {31'd0, busy}, {31'd0, m_busy});
        chk("cyc_done", {31'd0, done}, {31'd0, m_done});
        chk("cyc_bcd",  {16'd0, bcd},  {16'd0, m_bcd});
        chk("cyc_ovf",  {31'd0, ovf},  {31'd0, m_ovf});
        if (done === 1'b1) n_done++;
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic convert(input int v, input string nm);
        int cyc;
        bin   = W'(v);
        start = 1'b1;
        step();
        start = 1'b0;
        chk({nm, "_busy_next"}, {31'd0, busy}, 32'd1);
        cyc = 1;
        while (done !== 1'b1 && cyc < 60) begin
            step();
            cyc++;
        end
        chk({nm, "_latency"}, 32'(cyc - 1), 32'(LAT));
    endtask

    initial begin
        int n0;
        int cyc;
        int last;
        int seen;

        // Reset state
        repeat (3) step();
        chk("rst_bcd",  {16'd0, bcd}, 32'h0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        rst = 1'b0;
        step();

        convert(0, "zero");
        chk("zero_bcd", {16'd0, bcd}, 32'h0000);

        convert(1234, "v1234");
        chk("v1234_bcd", {16'd0, bcd}, 32'h1234);
        step();
        chk("v1234_done_single", {31'd0, done}, 32'd0);

        convert(9999, "v9999");
        chk("v9999_bcd", {16'd0, bcd}, 32'h9999);
        chk("v9999_ovf", {31'd0, ovf}, 32'd0);
        step();

        convert(16383, "vmax");
`ifdef BIN2BCD_SAT_EN
        chk("vmax_bcd", {16'd0, bcd}, 32'h9999);
        chk("vmax_ovf", {31'd0, ovf}, 32'd1);
`else
        chk("vmax_bcd", {16'd0, bcd}, 32'h6383);
        chk("vmax_ovf", {31'd0, ovf}, 32'd0);
`endif
        step();

        // Second start while busy is ignored
        n0    = n_done;
        bin   = W'(42);
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (3) step();
        bin   = W'(777);
        start = 1'b1;
        step();
        start = 1'b0;
        bin   = '0;
        repeat (40) step();
        chk("busy_ignore_ndone", 32'(n_done - n0), 32'd1);
        chk("busy_ignore_bcd", {16'd0, bcd}, 32'h0042);

        // Reset mid-conversion aborts
        bin   = W'(5000);
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (5) step();
        n0  = n_done;
        rst = 1'b1;
        #1;
        chk("abort_bcd",  {16'd0, bcd}, 32'h0);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        step();
        rst = 1'b0;
        repeat (20) step();
        chk("abort_no_done", 32'(n_done - n0), 32'd0);
        convert(10, "v10");
        chk("v10_bcd", {16'd0, bcd}, 32'h0010);
        step();

        // Start held high: back-to-back conversions
        bin   = W'(255);
        start = 1'b1;
        cyc   = 0;
        last  = -1;
        seen  = 0;
        while (seen < 4 && cyc < 100) begin
            step();
            cyc++;
            if (done === 1'b1) begin
                chk("held_bcd", {16'd0, bcd}, 32'h0255);
                if (last >= 0) chk("held_period", 32'(cyc - last), 32'(W + 2));
                last = cyc;
                seen++;
            end
        end
        chk("held_count", 32'(seen), 32'd4);
        start = 1'b0;
        repeat (20) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
